// File: rtl/mag_comp_seq_ctrl_if.sv
// Requester and comparator-slice signal bundle for mag_comp_seq_ctrl.
//
// Requester side:
//   start, abort, a_in, b_in       -> sequencer
//   busy, done, eq, gt, lt, err    <- sequencer
// Comparator slice side:
//   slice_a, slice_b               <- sequencer (4-bit operands to the slice)
//   slice_e, slice_g, slice_l      -> sequencer (slice verdict)
//
// master: the environment, which is the requester plus the comparator slice.
// slave:  the sequencer itself.
interface mag_comp_seq_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             err;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic             slice_e;
    logic             slice_g;
    logic             slice_l;

    modport master (
        output start, abort, a_in, b_in,
        input  busy, done, eq, gt, lt, err,
        input  slice_a, slice_b,
        output slice_e, slice_g, slice_l
    );

    modport slave (
        input  start, abort, a_in, b_in,
        output busy, done, eq, gt, lt, err,
        output slice_a, slice_b,
        input  slice_e, slice_g, slice_l
    );
endinterface

// File: rtl/mag_comp_seq_ctrl.sv
// Multi-cycle magnitude comparator sequencer.
//
// Compares two WIDTH-bit operands through one shared external 4-bit
// comparator slice, one nibble per cycle, most significant nibble first,
// stopping at the first unequal nibble. The final E/G/L verdict (or an error
// if the slice answer is not one-hot) is registered and held until the next
// accepted start.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mag_comp_seq_ctrl_if.slave: start/abort/a_in/b_in in,
//          busy/done/eq/gt/lt/err out, slice_a/slice_b out,
//          slice_e/slice_g/slice_l in
module mag_comp_seq_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    mag_comp_seq_ctrl_if.slave  bus
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCmp,
        StFin
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic               err_q, err_d;
    logic               slice_ok;

    assign slice_ok = $onehot({bus.slice_e, bus.slice_g, bus.slice_l});

    // Next-state logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    idx_d   = IDX_TOP;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = StCmp;
                end
            end
            StCmp: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (!slice_ok) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StFin;
                end else if (bus.slice_g) begin
                    gt_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = StFin;
                end else if (bus.slice_l) begin
                    lt_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = StFin;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = StFin;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                end
            end
            StFin: begin
                // start and abort are both ignored here; requester waits for busy==0
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= IDX_TOP;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            err_q   <= err_d;
        end
    end

    // Slice operands come straight from the operand registers so the slice
    // answer is available within the same CMP cycle.
    always_comb begin
        bus.slice_a = 4'h0;
        bus.slice_b = 4'h0;
        if (state_q == StCmp) begin
            bus.slice_a = a_q[{idx_q, 2'b00} +: 4];
            bus.slice_b = b_q[{idx_q, 2'b00} +: 4];
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;
    assign bus.eq   = eq_q;
    assign bus.gt   = gt_q;
    assign bus.lt   = lt_q;
    assign bus.err  = err_q;

endmodule
